// File: rtl/mm_mult.sv
// Iterative Montgomery multiplier: result = a*b*R^-1 mod n with R = 2^W.
// One WxW multiplier is time-shared across the MAB, MMP and MMN steps.
module mm_mult #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ce,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] n,
    input  logic [W-1:0] p,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAB,
        S_MMP,
        S_MMN,
        S_RED
    } state_t;

    state_t state_q, state_d;

    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   n_q, n_d;
    logic [W-1:0]   p_q, p_d;
    logic [W-1:0]   m_q, m_d;
    logic [W-1:0]   result_q, result_d;
    logic [2*W-1:0] t_q, t_d;
    logic [2*W:0]   u_q, u_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic [W-1:0]   mul_x, mul_y;
    logic [2*W-1:0] mul_p;
    logic [W:0]     red_t;
    logic [W:0]     red_n;
    logic [W:0]     red_diff;

    // Low half of U is zero for a correct p and the subtract's top bit is
    // dropped by the W-bit result; neither feeds any logic.
    logic           unused_bits;
    assign unused_bits = ^{u_q[W-1:0], red_diff[W]};

    always_comb begin
        mul_x = '0;
        mul_y = '0;
        unique case (state_q)
            S_MAB: begin
                mul_x = a_q;
                mul_y = b_q;
            end
            S_MMP: begin
                mul_x = t_q[W-1:0];
                mul_y = p_q;
            end
            S_MMN: begin
                mul_x = m_q;
                mul_y = n_q;
            end
            default: begin
                mul_x = '0;
                mul_y = '0;
            end
        endcase
    end

    assign mul_p    = {{W{1'b0}}, mul_x} * {{W{1'b0}}, mul_y};
    assign red_t    = u_q[2*W:W];
    assign red_n    = {1'b0, n_q};
    assign red_diff = red_t - red_n;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        n_d      = n_q;
        p_d      = p_q;
        m_d      = m_q;
        t_d      = t_q;
        u_d      = u_q;
        result_d = result_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    n_d     = n;
                    p_d     = p;
                    busy_d  = 1'b1;
                    state_d = S_MAB;
                end
            end
            S_MAB: begin
                t_d     = mul_p;
                state_d = S_MMP;
            end
            S_MMP: begin
                m_d     = mul_p[W-1:0];
                state_d = S_MMN;
            end
            S_MMN: begin
                u_d     = {1'b0, t_q} + {1'b0, mul_p};
                state_d = S_RED;
            end
            S_RED: begin
                result_d = (red_t >= red_n) ? red_diff[W-1:0] : red_t[W-1:0];
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            n_q      <= '0;
            p_q      <= '0;
            m_q      <= '0;
            t_q      <= '0;
            u_q      <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (ce) begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            n_q      <= n_d;
            p_q      <= p_d;
            m_q      <= m_d;
            t_q      <= t_d;
            u_q      <= u_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: doc/mm_mult.md
Name: mm_mult

Overview:
- Montgomery multiplier; the consumer of the Montgomery parameter p that the setup block produces.
- Computes result = a*b*R^-1 mod n, with R = 2^W.
- Sits downstream of the setup block in the modular-exponentiation datapath.
- Takes operands already in Montgomery form, plus n and p = -n^-1 mod R, and returns a fully reduced product.
- Iterative: one start/done transaction per product.

Parameters:
W, 16, operand/modulus width in bits; R = 2^W

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
ce  input  1  clock enable; low freezes all state (no progress, outputs held)
start  input  1  request; sampled only in IDLE with ce=1
a  input  W  operand A, Montgomery form, a < n
b  input  W  operand B, Montgomery form, b < n
n  input  W  modulus, odd
p  input  W  -n^-1 mod 2^W (setup block output)
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse: result valid
result  output  W  a*b*R^-1 mod n; held until next done

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, result=0; all internal registers=0.
- Reset mid-operation aborts with no done pulse.
- Clock enable: every register, including done, updates only when ce=1.
  - With ce=0 the FSM holds its state.
  - done, if high, stays high until the next ce=1 edge.
- States and transitions (each transition takes one ce=1 edge):
  - IDLE: if start, latch a, b, n, p into internal registers, go to MAB, busy<=1; otherwise stay.
  - MAB: T <= a*b (2W bits).
  - MMP: m <= (T[W-1:0]*p) mod 2^W (low W bits only).
  - MMN: U <= T + m*n (2W+1 bits; carry kept).
  - RED: t = U[2W:W] (W+1 bits); result <= (t >= n) ? t-n : t; done<=1; busy<=0; go to IDLE.
- Latency:
  - start sampled at edge k gives done=1 and result valid after edge k+4, with ce continuously high.
  - Each ce=0 cycle adds one cycle.
- Back-to-back: a new start may be presented in the cycle done is high and is accepted at that edge, since the FSM is in IDLE. Throughput is one product per 5 cycles.
- start while busy is ignored, not queued. Input changes while busy have no effect because operands are latched.
- Widths:
  - U low W bits are always zero when p is correct.
  - t < 2n always holds, so a single conditional subtract fully reduces.
  - The compare is (W+1)-bit unsigned.
- Out-of-contract inputs (even n, wrong p, a or b >= n): the same arithmetic is applied deterministically and done still pulses. No error flag.
- Exactly one multiplier result is consumed per state. The implementation may share a single WxW multiplier across MAB, MMP and MMN.

Test Plan:
- W=16, n=0xFFF1, p=0xEEEF, a=0x000F, b=0x000F, start one cycle -> done 4 edges later, result=0x000F (Montgomery 1*1). busy high for exactly 4 cycles.
- Same n and p, a=0x0001, b=0x0001 -> result=0xEEE1 (R^-1 mod n). Internal m=0xEEEF, t=0xEEE1, no subtract.
- Same n and p, a=b=0xFFF0 -> T low half 0x0100, m=0xEF00, t=0x1EED2 (17-bit), final subtract taken, result=0xEEE1.
- a=0x0000, b=0x1234 -> result=0x0000. Then start again in the done cycle with a=b=0x000F -> second done exactly 5 cycles after the first, result=0x000F.
- Stall and ignore case: start, drop ce for 3 cycles during MMP, pulse start again while busy -> done 7 edges after the first start, one done pulse only, result correct.
- Reset case: assert rst_n=0 asynchronously in MMN -> busy, done and result go to 0 immediately, no done afterwards. After release, the FSM is in IDLE and the next transaction completes normally.
